memory_bus_if_core: RTL and testbench

MEMORY_BUS_IF_CORE -- requirements
Module: memory_bus_if

---
 rtl/memory_bus_if_core_pkg.sv | 31 +++
 rtl/memory_bus_if_core_bus_write_strobe.sv | 65 ++++++
 rtl/memory_bus_if_core.sv | 158 +++++++++++++++
 tb/tb_memory_bus_if_core.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/memory_bus_if_core_pkg.sv
// Shared constants for the CPU-to-BRAM memory bus interface.
//   - bram_select_t : target decode of CPU_ADDR[16:15]
//   - BRAM_CNT_SELECT_* : controller sub-block codes held in address bits [11:8]
//   - ADDR_* : controller register addresses that are snooped to track
//              the page/segment state used to widen target addresses
package memory_bus_if_core_pkg;

  typedef enum logic [1:0] {
    BRAM_SELECT_CONTROLLER = 2'h0,
    BRAM_SELECT_MOD        = 2'h1,
    BRAM_SELECT_DUTY_TABLE = 2'h2,
    BRAM_SELECT_STM        = 2'h3
  } bram_select_t;

  localparam logic [3:0] BRAM_CNT_SELECT_MAIN  = 4'h0;
  localparam logic [3:0] BRAM_CNT_SELECT_CLOCK = 4'h1;

  localparam logic [13:0] ADDR_MOD_MEM_WR_SEGMENT                = 14'h0020;
  localparam logic [13:0] ADDR_STM_MEM_WR_SEGMENT                = 14'h0050;
  localparam logic [13:0] ADDR_STM_MEM_WR_PAGE                   = 14'h0051;
  localparam logic [13:0] ADDR_PULSE_WIDTH_ENCODER_TABLE_WR_PAGE = 14'h00A0;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 16;

  // Controller sub-block code carried in a controller word address.
  function automatic logic [3:0] cnt_select(input logic [ADDR_W-1:0] addr);
    return addr[11:8];
  endfunction

endpackage

// File: rtl/memory_bus_if_core_bus_write_strobe.sv
// bus_write_strobe: first-stage (s1) register of the CPU bus signals plus
// edge detection of the combined write condition EN & WE.
// Ports:
//   BUS_CLK, RST_N      clock, asynchronous active-low reset
//   EN, WE              chip enable / write enable (active high)
//   BRAM_SELECT         target select
//   BRAM_ADDR, DATA_IN  word address / write data
//   s1_*                registered copies of the bus inputs
//   strobe              one-cycle write request, combinational from s1
module bus_write_strobe
  import memory_bus_if_core_pkg::*;
(
  input  logic              BUS_CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic              WE,
  input  logic [1:0]        BRAM_SELECT,
  input  logic [ADDR_W-1:0] BRAM_ADDR,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic              s1_en,
  output logic              s1_we,
  output bram_select_t      s1_sel,
  output logic [ADDR_W-1:0] s1_addr,
  output logic [DATA_W-1:0] s1_data,
  output logic              strobe
);

  logic s1_act;
  logic act_prev;
  logic armed;

  always_ff @(posedge BUS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_en   <= 1'b0;
      s1_we   <= 1'b0;
      s1_sel  <= BRAM_SELECT_CONTROLLER;
      s1_addr <= '0;
      s1_data <= '0;
    end else begin
      s1_en   <= EN;
      s1_we   <= WE;
      s1_sel  <= bram_select_t'(BRAM_SELECT);
      s1_addr <= BRAM_ADDR;
      s1_data <= DATA_IN;
    end
  end

  assign s1_act = s1_en & s1_we;

  // act_prev gives the rising-edge detect. armed blocks an access that was
  // already active when reset released: it only sets once the raw bus has
  // been seen idle, so the s1 history (cleared to 0) cannot fake an edge.
  always_ff @(posedge BUS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      act_prev <= 1'b0;
      armed    <= 1'b0;
    end else begin
      act_prev <= s1_act;
      armed    <= armed | ~(EN & WE);
    end
  end

  assign strobe = s1_act & ~act_prev & armed;

endmodule

// File: rtl/memory_bus_if_core.sv
// memory_bus_if_core: CPU bus to BRAM write-port fan-out.
// Registers the CPU bus once, generates a single write strobe per access,
// decodes it onto one of four BRAM write ports and snoops controller writes
// that set the page/segment bits prepended to the target addresses.
// Ports:
//   BUS_CLK, RST_N                     clock, asynchronous active-low reset
//   EN, WE, BRAM_SELECT, BRAM_ADDR,
//   DATA_IN                            CPU bus (active-high enables)
//   CNT_WE/ADDR/WDATA                  controller write port (14-bit addr)
//   MOD_WE/ADDR/WDATA                  modulation port {mod_segment, addr}
//   DUTY_WE/ADDR/WDATA                 duty table port {duty_page, addr}
//   STM_WE/ADDR/WDATA                  STM port {stm_segment, stm_page, addr}
//   CNT_RDATA, DATA_OUT                controller read data / registered CPU read data
module memory_bus_if_core
  import memory_bus_if_core_pkg::*;
(
  input  logic        BUS_CLK,
  input  logic        RST_N,
  input  logic        EN,
  input  logic        WE,
  input  logic [1:0]  BRAM_SELECT,
  input  logic [13:0] BRAM_ADDR,
  input  logic [15:0] DATA_IN,
  output logic        CNT_WE,
  output logic [13:0] CNT_ADDR,
  output logic [15:0] CNT_WDATA,
  output logic        MOD_WE,
  output logic [14:0] MOD_ADDR,
  output logic [15:0] MOD_WDATA,
  output logic        DUTY_WE,
  output logic [14:0] DUTY_ADDR,
  output logic [15:0] DUTY_WDATA,
  output logic        STM_WE,
  output logic [18:0] STM_ADDR,
  output logic [15:0] STM_WDATA,
  input  logic [15:0] CNT_RDATA,
  output logic [15:0] DATA_OUT
);

  logic              s1_en;
  logic              s1_we;
  bram_select_t      s1_sel;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W-1:0] s1_data;
  logic              strobe;

  logic       mod_segment;
  logic       stm_segment;
  logic [3:0] stm_page;
  logic       duty_page;

  logic cnt_hit;
  logic mod_hit;
  logic duty_hit;
  logic stm_hit;
  logic rd_hit;

  bus_write_strobe u_strobe (
    .BUS_CLK     (BUS_CLK),
    .RST_N       (RST_N),
    .EN          (EN),
    .WE          (WE),
    .BRAM_SELECT (BRAM_SELECT),
    .BRAM_ADDR   (BRAM_ADDR),
    .DATA_IN     (DATA_IN),
    .s1_en       (s1_en),
    .s1_we       (s1_we),
    .s1_sel      (s1_sel),
    .s1_addr     (s1_addr),
    .s1_data     (s1_data),
    .strobe      (strobe)
  );

  always_comb begin
    cnt_hit  = 1'b0;
    mod_hit  = 1'b0;
    duty_hit = 1'b0;
    stm_hit  = 1'b0;
    if (strobe) begin
      unique case (s1_sel)
        BRAM_SELECT_CONTROLLER: cnt_hit  = 1'b1;
        BRAM_SELECT_MOD:        mod_hit  = 1'b1;
        BRAM_SELECT_DUTY_TABLE: duty_hit = 1'b1;
        BRAM_SELECT_STM:        stm_hit  = 1'b1;
        default: ;
      endcase
    end
  end

  assign rd_hit = s1_en & ~s1_we & (s1_sel == BRAM_SELECT_CONTROLLER);

  always_ff @(posedge BUS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      CNT_WE     <= 1'b0;
      CNT_ADDR   <= '0;
      CNT_WDATA  <= '0;
      MOD_WE     <= 1'b0;
      MOD_ADDR   <= '0;
      MOD_WDATA  <= '0;
      DUTY_WE    <= 1'b0;
      DUTY_ADDR  <= '0;
      DUTY_WDATA <= '0;
      STM_WE     <= 1'b0;
      STM_ADDR   <= '0;
      STM_WDATA  <= '0;
    end else begin
      CNT_WE  <= cnt_hit;
      MOD_WE  <= mod_hit;
      DUTY_WE <= duty_hit;
      STM_WE  <= stm_hit;
      if (cnt_hit) begin
        CNT_ADDR  <= s1_addr;
        CNT_WDATA <= s1_data;
      end
      if (mod_hit) begin
        MOD_ADDR  <= {mod_segment, s1_addr};
        MOD_WDATA <= s1_data;
      end
      if (duty_hit) begin
        DUTY_ADDR  <= {duty_page, s1_addr};
        DUTY_WDATA <= s1_data;
      end
      if (stm_hit) begin
        STM_ADDR  <= {stm_segment, stm_page, s1_addr};
        STM_WDATA <= s1_data;
      end
    end
  end

  // Page/segment state lands on the same edge as CNT_WE. A following data
  // write needs an idle s1 cycle before its strobe, so it always sees the
  // updated value.
  always_ff @(posedge BUS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      mod_segment <= 1'b0;
      stm_segment <= 1'b0;
      stm_page    <= '0;
      duty_page   <= 1'b0;
    end else if (cnt_hit && cnt_select(s1_addr) == BRAM_CNT_SELECT_MAIN) begin
      unique case (s1_addr)
        ADDR_MOD_MEM_WR_SEGMENT:                mod_segment <= s1_data[0];
        ADDR_STM_MEM_WR_SEGMENT:                stm_segment <= s1_data[0];
        ADDR_STM_MEM_WR_PAGE:                   stm_page    <= s1_data[3:0];
        ADDR_PULSE_WIDTH_ENCODER_TABLE_WR_PAGE: duty_page   <= s1_data[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      DATA_OUT <= '0;
    end else if (rd_hit) begin
      DATA_OUT <= CNT_RDATA;
    end
  end

endmodule

// File: tb/tb_memory_bus_if_core.sv
module tb_memory_bus_if_core;

  logic        BUS_CLK = 1'b0;
  logic        RST_N   = 1'b0;
  logic        EN      = 1'b0;
  logic        WE      = 1'b0;
  logic [1:0]  BRAM_SELECT = '0;
  logic [13:0] BRAM_ADDR   = '0;
  logic [15:0] DATA_IN     = '0;
  logic [15:0] CNT_RDATA   = '0;
  logic        CNT_WE, MOD_WE, DUTY_WE, STM_WE;
  logic [13:0] CNT_ADDR;
  logic [14:0] MOD_ADDR, DUTY_ADDR;
  logic [18:0] STM_ADDR;
  logic [15:0] CNT_WDATA, MOD_WDATA, DUTY_WDATA, STM_WDATA, DATA_OUT;

  memory_bus_if_core dut (
    .BUS_CLK    (BUS_CLK),
    .RST_N      (RST_N),
    .EN         (EN),
    .WE         (WE),
    .BRAM_SELECT(BRAM_SELECT),
    .BRAM_ADDR  (BRAM_ADDR),
    .DATA_IN    (DATA_IN),
    .CNT_WE     (CNT_WE),
    .CNT_ADDR   (CNT_ADDR),
    .CNT_WDATA  (CNT_WDATA),
    .MOD_WE     (MOD_WE),
    .MOD_ADDR   (MOD_ADDR),
    .MOD_WDATA  (MOD_WDATA),
    .DUTY_WE    (DUTY_WE),
    .DUTY_ADDR  (DUTY_ADDR),
    .DUTY_WDATA (DUTY_WDATA),
    .STM_WE     (STM_WE),
    .STM_ADDR   (STM_ADDR),
    .STM_WDATA  (STM_WDATA),
    .CNT_RDATA  (CNT_RDATA),
    .DATA_OUT   (DATA_OUT)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // Pulse monitor: counts high cycles per target and captures address/data.
  int unsigned pulses   [4];
  logic [18:0] cap_addr [4];
  logic [15:0] cap_data [4];
  int unsigned multi_hi = 0;

  initial begin
    for (int i = 0; i < 4; i++) begin
      pulses[i]   = 0;
      cap_addr[i] = '0;
      cap_data[i] = '0;
    end
  end

  always @(negedge BUS_CLK) begin
    if (CNT_WE)  begin pulses[0]++; cap_addr[0] = {5'b0, CNT_ADDR};  cap_data[0] = CNT_WDATA;  end
    if (MOD_WE)  begin pulses[1]++; cap_addr[1] = {4'b0, MOD_ADDR};  cap_data[1] = MOD_WDATA;  end
    if (DUTY_WE) begin pulses[2]++; cap_addr[2] = {4'b0, DUTY_ADDR}; cap_data[2] = DUTY_WDATA; end
    if (STM_WE)  begin pulses[3]++; cap_addr[3] = STM_ADDR;          cap_data[3] = STM_WDATA;  end
    if (int'(CNT_WE) + int'(MOD_WE) + int'(DUTY_WE) + int'(STM_WE) > 1) multi_hi++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic snap(output int unsigned s [4]);
    for (int i = 0; i < 4; i++) s[i] = pulses[i];
  endtask

  function automatic int unsigned others(input int unsigned s [4], input int unsigned tgt);
    int unsigned sum = 0;
    for (int i = 0; i < 4; i++)
      if (i != int'(tgt)) sum += pulses[i] - s[i];
    return sum;
  endfunction

  // One access: EN=WE=1 for 'hold' cycles, then idle, then check one pulse
  // on target 'tgt' with the expected widened address and data.
  task automatic wr(input string name, input logic [1:0] sel, input logic [13:0] addr,
                    input logic [15:0] data, input int unsigned hold,
                    input int unsigned tgt, input logic [18:0] exp_addr);
    int unsigned s [4];
    @(negedge BUS_CLK);
    snap(s);
    EN = 1'b1; WE = 1'b1; BRAM_SELECT = sel; BRAM_ADDR = addr; DATA_IN = data;
    repeat (hold) @(negedge BUS_CLK);
    EN = 1'b0; WE = 1'b0;
    repeat (4) @(negedge BUS_CLK);
    #1;
    chk({name, " pulses"}, pulses[tgt] - s[tgt], 1);
    chk({name, " others"}, others(s, tgt), 0);
    chk({name, " addr"}, {13'b0, cap_addr[tgt]}, {13'b0, exp_addr});
    chk({name, " data"}, {16'b0, cap_data[tgt]}, {16'b0, data});
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " we"}, {28'b0, CNT_WE, MOD_WE, DUTY_WE, STM_WE}, 0);
    chk({name, " cnt"}, {2'b0, CNT_ADDR, CNT_WDATA}, 0);
    chk({name, " mod"}, {1'b0, MOD_ADDR, MOD_WDATA}, 0);
    chk({name, " duty"}, {1'b0, DUTY_ADDR, DUTY_WDATA}, 0);
    chk({name, " stm"}, {STM_ADDR[15:0], STM_WDATA}, 0);
    chk({name, " stm_hi"}, {29'b0, STM_ADDR[18:16]}, 0);
    chk({name, " dout"}, {16'b0, DATA_OUT}, 0);
  endtask

  typedef struct {
    string       name;
    logic [1:0]  sel;
    logic [13:0] addr;
    logic [15:0] data;
    int unsigned hold;
    int unsigned tgt;
    logic [18:0] exp_addr;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int unsigned s [4];

    vecs[0]  = '{"mod_basic",  2'd1, 14'h0005, 16'hABCD, 2, 1, 19'h00005};
    vecs[1]  = '{"cnt_basic",  2'd0, 14'h0123, 16'h1111, 1, 0, 19'h00123};
    vecs[2]  = '{"duty_hold3", 2'd2, 14'h3FFF, 16'hBEEF, 3, 2, 19'h03FFF};
    vecs[3]  = '{"stm_p0",     2'd3, 14'h0010, 16'h1234, 1, 3, 19'h00010};
    vecs[4]  = '{"set_modseg", 2'd0, 14'h0020, 16'h0001, 1, 0, 19'h00020};
    vecs[5]  = '{"mod_seg1",   2'd1, 14'h0007, 16'h7777, 1, 1, 19'h04007};
    vecs[6]  = '{"set_stmseg", 2'd0, 14'h0050, 16'h0001, 1, 0, 19'h00050};
    vecs[7]  = '{"set_stmpg",  2'd0, 14'h0051, 16'h0003, 1, 0, 19'h00051};
    vecs[8]  = '{"stm_s1p3",   2'd3, 14'h0010, 16'h1234, 1, 3, 19'h4C010};
    vecs[9]  = '{"set_dutypg", 2'd0, 14'h00A0, 16'h0001, 1, 0, 19'h000A0};
    vecs[10] = '{"duty_pg1",   2'd2, 14'h0001, 16'h5555, 1, 2, 19'h04001};
    vecs[11] = '{"clr_modseg", 2'd0, 14'h0020, 16'hFFFE, 2, 0, 19'h00020};
    vecs[12] = '{"mod_seg0",   2'd1, 14'h0002, 16'h2222, 1, 1, 19'h00002};

    // Reset state
    repeat (3) @(negedge BUS_CLK);
    chk_all_zero("reset");
    RST_N = 1'b1;
    repeat (2) @(negedge BUS_CLK);
    chk_all_zero("post_release");

    for (int i = 0; i < 13; i++)
      wr(vecs[i].name, vecs[i].sel, vecs[i].addr, vecs[i].data,
         vecs[i].hold, vecs[i].tgt, vecs[i].exp_addr);

    // Latency: two edges from the edge that samples EN=WE=1
    @(negedge BUS_CLK);
    EN = 1'b1; WE = 1'b1; BRAM_SELECT = 2'd1; BRAM_ADDR = 14'h0009; DATA_IN = 16'h9999;
    @(posedge BUS_CLK); #1;
    chk("lat_edge1", {31'b0, MOD_WE}, 0);
    @(negedge BUS_CLK);
    EN = 1'b0; WE = 1'b0;
    @(posedge BUS_CLK); #1;
    chk("lat_edge2", {31'b0, MOD_WE}, 1);
    chk("lat_addr", {17'b0, MOD_ADDR}, 32'h0009);
    @(posedge BUS_CLK); #1;
    chk("lat_edge3", {31'b0, MOD_WE}, 0);

    // Controller read
    @(negedge BUS_CLK);
    EN = 1'b1; WE = 1'b0; BRAM_SELECT = 2'd0; BRAM_ADDR = 14'h0100; CNT_RDATA = 16'h5A5A;
    @(posedge BUS_CLK); #1;
    chk("rd_edge1", {16'b0, DATA_OUT}, 0);
    @(posedge BUS_CLK); #1;
    chk("rd_edge2", {16'b0, DATA_OUT}, 32'h5A5A);
    @(negedge BUS_CLK);
    EN = 1'b0;
    repeat (2) @(negedge BUS_CLK);
    CNT_RDATA = 16'h1357;
    repeat (3) @(negedge BUS_CLK);
    chk("rd_hold_en0", {16'b0, DATA_OUT}, 32'h5A5A);
    EN = 1'b1; WE = 1'b0; BRAM_SELECT = 2'd1;
    repeat (3) @(negedge BUS_CLK);
    chk("rd_hold_sel1", {16'b0, DATA_OUT}, 32'h5A5A);
    EN = 1'b0;
    repeat (2) @(negedge BUS_CLK);

    // WE toggling with EN low must never strobe
    snap(s);
    BRAM_SELECT = 2'd2;
    WE = 1'b1; repeat (2) @(negedge BUS_CLK);
    WE = 1'b0; @(negedge BUS_CLK);
    WE = 1'b1; @(negedge BUS_CLK);
    WE = 1'b0; repeat (4) @(negedge BUS_CLK);
    #1;
    chk("en0_no_strobe", others(s, 4), 0);

    // Reset mid-write after s1 captured the access; access held across release
    wr("pre_rst_modseg", 2'd0, 14'h0020, 16'h0001, 1, 0, 19'h00020);
    @(negedge BUS_CLK);
    snap(s);
    EN = 1'b1; WE = 1'b1; BRAM_SELECT = 2'd1; BRAM_ADDR = 14'h0003; DATA_IN = 16'h3333;
    @(posedge BUS_CLK); #1;
    RST_N = 1'b0;
    #2;
    chk_all_zero("mid_rst");
    repeat (2) @(negedge BUS_CLK);
    RST_N = 1'b1;
    repeat (5) @(negedge BUS_CLK);
    #1;
    chk("rst_no_pulse", others(s, 4), 0);
    EN = 1'b0; WE = 1'b0;
    repeat (2) @(negedge BUS_CLK);
    wr("rst_mod", 2'd1, 14'h0003, 16'h3333, 1, 1, 19'h00003);
    wr("rst_stm", 2'd3, 14'h0005, 16'h4444, 1, 3, 19'h00005);
    wr("rst_duty", 2'd2, 14'h0006, 16'h6666, 1, 2, 19'h00006);

    // Duty sweep across the page flip: 15'h3FF0..15'h400F contiguous, then top word
    for (int i = 0; i < 16; i++)
      wr("duty_lo", 2'd2, 14'(14'h3FF0 + i), 16'(16'hD000 + i), 1, 2, 19'(19'h03FF0 + i));
    wr("duty_flip", 2'd0, 14'h00A0, 16'h0001, 1, 0, 19'h000A0);
    for (int i = 0; i < 16; i++)
      wr("duty_hi", 2'd2, 14'(i), 16'(16'hE000 + i), 1, 2, 19'(19'h04000 + i));
    wr("duty_top", 2'd2, 14'h3FFF, 16'hFFFF, 1, 2, 19'h07FFF);

    chk("one_hot_we", multi_hi, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
